// File: rtl/fpnew_divsqrt_arbiter.sv
// ---------------------------------------------------------------------------
// fpnew_divsqrt_arbiter
//
// Shares one multi-cycle, single-outstanding FP div/sqrt unit among NumReq
// requesters. Requests are arbitrated round-robin. The winner's payload is
// forwarded to the unit. The owner of the in-flight operation is recorded so
// that the unit's result is routed back to that requester only.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              kill all in-flight work (highest priority)
//   req_valid_i/ready_o  per-requester issue handshake
//   req_payload_i        per-requester opaque request bits
//   resp_valid_o/ready_i per-requester response handshake
//   resp_payload_o       unit result, broadcast to all requesters
//   unit_valid_o/ready_i issue handshake towards the unit
//   unit_payload_o       payload of the granted requester
//   unit_flush_o         flush forwarded to the unit
//   unit_out_*           result handshake from the unit
//   owner_o              requester owning the in-flight op
//   busy_o               offer locked or op in flight
// ---------------------------------------------------------------------------
module fpnew_divsqrt_arbiter #(
  parameter int unsigned NumReq       = 4,
  parameter int unsigned PayloadWidth = 136,
  parameter int unsigned RespWidth    = 69,
  localparam int unsigned IdxW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0]  req_payload_i,
  output logic [NumReq-1:0]                    resp_valid_o,
  input  logic [NumReq-1:0]                    resp_ready_i,
  output logic [RespWidth-1:0]                 resp_payload_o,
  output logic                                 unit_valid_o,
  input  logic                                 unit_ready_i,
  output logic [PayloadWidth-1:0]              unit_payload_o,
  output logic                                 unit_flush_o,
  input  logic                                 unit_out_valid_i,
  output logic                                 unit_out_ready_o,
  input  logic [RespWidth-1:0]                 unit_out_payload_i,
  output logic [IdxW-1:0]                      owner_o,
  output logic                                 busy_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] owner_q;
  logic            lock_q;

  logic [IdxW-1:0] scan_grant;
  logic [IdxW-1:0] scan_idx;
  logic            scan_found;
  logic [IdxW-1:0] grant;
  logic [IdxW-1:0] next_rr;
  logic            issue_fire;
  logic            issue_stall;
  logic            done_fire;

  // First valid requester at or above rr_ptr, wrapping modulo NumReq.
  always_comb begin
    scan_grant = rr_ptr_q;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      scan_idx = IdxW'((int'(rr_ptr_q) + i) % NumReq);
      if (!scan_found && req_valid_i[scan_idx]) begin
        scan_found = 1'b1;
        scan_grant = scan_idx;
      end
    end
  end

  // A stalled offer keeps its winner so the unit sees a stable request.
  assign grant   = lock_q ? grant_q : scan_grant;
  assign next_rr = (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;

  assign issue_fire  = (state_q == IDLE) & ~flush_i & (|req_valid_i) & unit_ready_i;
  assign issue_stall = (state_q == IDLE) & ~flush_i & (|req_valid_i) & ~unit_ready_i;
  assign done_fire   = (state_q == WAIT) & ~flush_i & unit_out_valid_i & resp_ready_i[owner_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    unit_valid_o     = 1'b0;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    unit_out_ready_o = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          unit_valid_o       = |req_valid_i;
          req_ready_o[grant] = unit_ready_i & req_valid_i[grant];
          if (issue_fire) state_d = WAIT;
        end
        WAIT: begin
          resp_valid_o[owner_q] = unit_out_valid_i;
          unit_out_ready_o      = resp_ready_i[owner_q];
          if (done_fire) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      lock_q   <= 1'b0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else if (issue_fire) begin
      owner_q  <= grant;
      rr_ptr_q <= next_rr;
      lock_q   <= 1'b0;
    end else if (issue_stall) begin
      grant_q <= grant;
      lock_q  <= 1'b1;
    end
  end

  assign unit_payload_o = req_payload_i[grant];
  assign resp_payload_o = unit_out_payload_i;
  assign unit_flush_o   = flush_i;
  assign owner_o        = owner_q;
  assign busy_o         = (state_q == WAIT) | lock_q;

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
module tb_fpnew_divsqrt_arbiter;

  localparam int N  = 4;
  localparam int PW = 136;
  localparam int RW = 69;
  localparam int IW = 2;

  logic                 clk;
  logic                 rst_ni;
  logic                 flush;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][PW-1:0] req_payload;
  logic [N-1:0]         resp_valid;
  logic [N-1:0]         resp_ready;
  logic [RW-1:0]        resp_payload;
  logic                 unit_valid;
  logic                 unit_ready;
  logic [PW-1:0]        unit_payload;
  logic                 unit_flush;
  logic                 unit_out_valid;
  logic                 unit_out_ready;
  logic [RW-1:0]        unit_out_payload;
  logic [IW-1:0]        owner;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  fpnew_divsqrt_arbiter #(.NumReq(N), .PayloadWidth(PW), .RespWidth(RW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (flush),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_payload_i      (req_payload),
    .resp_valid_o       (resp_valid),
    .resp_ready_i       (resp_ready),
    .resp_payload_o     (resp_payload),
    .unit_valid_o       (unit_valid),
    .unit_ready_i       (unit_ready),
    .unit_payload_o     (unit_payload),
    .unit_flush_o       (unit_flush),
    .unit_out_valid_i   (unit_out_valid),
    .unit_out_ready_o   (unit_out_ready),
    .unit_out_payload_i (unit_out_payload),
    .owner_o            (owner),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one shared server, a round-robin pointer, a possibly
  // pending (stalled) offer, and the owner of the op currently served.
  bit m_wait;
  bit m_locked;
  int m_lock_g;
  int m_owner;
  int m_rr;
  int grant_log[$];

  function automatic int exp_grant();
    if (m_locked) return m_lock_g;
    for (int i = 0; i < N; i++) begin
      if (req_valid[(m_rr + i) % N]) return (m_rr + i) % N;
    end
    return m_rr;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    int g;
    if (!rst_ni) begin
      m_wait   <= 1'b0;
      m_locked <= 1'b0;
      m_lock_g <= 0;
      m_owner  <= 0;
      m_rr     <= 0;
    end else begin
      g = exp_grant();
      if (flush) begin
        m_wait   <= 1'b0;
        m_locked <= 1'b0;
      end else if (!m_wait) begin
        if (|req_valid) begin
          if (unit_ready) begin
            m_owner  <= g;
            m_rr     <= (g + 1) % N;
            m_wait   <= 1'b1;
            m_locked <= 1'b0;
            grant_log.push_back(g);
          end else begin
            m_locked <= 1'b1;
            m_lock_g <= g;
          end
        end
      end else if (unit_out_valid && resp_ready[m_owner]) begin
        m_wait <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] e_rr;
    logic [N-1:0] e_rv;
    logic e_uv;
    logic e_or;
    g    = exp_grant();
    e_uv = !flush && !m_wait && (|req_valid);
    e_rr = '0;
    if (e_uv && req_valid[g]) e_rr[g] = unit_ready;
    e_rv = '0;
    if (!flush && m_wait) e_rv[m_owner] = unit_out_valid;
    e_or = !flush && m_wait && resp_ready[m_owner];
    check("unit_valid", 256'(unit_valid), 256'(e_uv));
    check("req_ready", 256'(req_ready), 256'(e_rr));
    check("resp_valid", 256'(resp_valid), 256'(e_rv));
    check("unit_out_ready", 256'(unit_out_ready), 256'(e_or));
    check("busy", 256'(busy), 256'(m_wait || m_locked));
    check("owner", 256'(owner), 256'(m_owner));
    check("resp_payload", 256'(resp_payload), 256'(unit_out_payload));
    check("unit_flush", 256'(unit_flush), 256'(flush));
    if (e_uv) check("unit_payload", 256'(unit_payload), 256'(req_payload[g]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue with mask held, wait lat cycles, return result with all ready.
  task automatic do_op(input logic [N-1:0] mask, input int lat);
    req_valid  = mask;
    unit_ready = 1'b1;
    step();
    unit_ready = 1'b0;
    repeat (lat) step();
    unit_out_valid   = 1'b1;
    unit_out_payload = RW'({$urandom, $urandom, $urandom});
    resp_ready       = '1;
    step();
    unit_out_valid = 1'b0;
    resp_ready     = '0;
    req_valid      = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b1; flush = 1'b0; req_valid = '0; resp_ready = '0;
    unit_ready = 1'b0; unit_out_valid = 1'b0; unit_out_payload = '0;
    for (int i = 0; i < N; i++) req_payload[i] = {8'(i + 1), 64'hC0DE_0000_0000_0000 + 64'(i), 64'(i * 17 + 3)};
    #1 rst_ni = 1'b0;
    #1;
    check("rst_resp_valid", 256'(resp_valid), 256'(0));
    check("rst_out_ready", 256'(unit_out_ready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_owner", 256'(owner), 256'(0));
    step(); step();
    rst_ni = 1'b1;
    step();

    // Single request from requester 2.
    req_valid = 4'b0100; unit_ready = 1'b1;
    #1 check("single_ready", 256'(req_ready), 256'(4'b0100));
    step();
    req_valid = '0; unit_ready = 1'b0;
    check("single_owner", 256'(owner), 256'(2));
    check("single_busy", 256'(busy), 256'(1));
    repeat (9) step();
    unit_out_valid = 1'b1; resp_ready = 4'b0100; unit_out_payload = RW'(69'h1_2345_6789_ABCD_EF01);
    #1 check("single_resp", 256'(resp_valid), 256'(4'b0100));
    step();
    unit_out_valid = 1'b0; resp_ready = '0;
    #1 check("single_resp_once", 256'(resp_valid), 256'(0));

    // rr_ptr is now 3: requester 3 wins over 0.
    req_valid = 4'b1001; unit_ready = 1'b1;
    #1 check("rr_after_2", 256'(req_ready), 256'(4'b1000));
    unit_ready = 1'b0;
    do_op(4'b1001, 2);

    // Fairness with all requesting.
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b1111; unit_ready = 1'b1;
      #1 check("fair_grant", 256'(req_ready), 256'(4'b0001 << (k % 4)));
      do_op(4'b1111, 3);
    end
    check("log_0", 256'(grant_log[0]), 256'(2));
    check("log_1", 256'(grant_log[1]), 256'(3));
    for (int k = 0; k < 8; k++) check("log_fair", 256'(grant_log[k + 2]), 256'(k % 4));

    // Lock stability: requester 1 offered but stalled.
    req_valid = 4'b0010; unit_ready = 1'b0;
    repeat (3) step();
    check("lock_payload", 256'(unit_payload), 256'(req_payload[1]));
    check("lock_busy", 256'(busy), 256'(1));
    req_valid = 4'b0011;
    step();
    check("lock_payload_hold", 256'(unit_payload), 256'(req_payload[1]));
    unit_ready = 1'b1;
    #1 check("lock_ready", 256'(req_ready), 256'(4'b0010));
    step();
    unit_ready = 1'b0;
    check("lock_owner", 256'(owner), 256'(1));

    // Response backpressure from owner 1, others pending.
    req_valid = 4'b1101; unit_out_valid = 1'b1; resp_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_out_ready", 256'(unit_out_ready), 256'(0));
      check("bp_no_issue", 256'(unit_valid), 256'(0));
      check("bp_busy", 256'(busy), 256'(1));
    end
    resp_ready = 4'b0010;
    step();
    unit_out_valid = 1'b0; resp_ready = '0; req_valid = '0;

    // Flush while waiting on requester 0.
    req_valid = 4'b0001; unit_ready = 1'b1;
    step();
    req_valid = '0; unit_ready = 1'b0;
    repeat (3) step();
    flush = 1'b1;
    #1 check("flush_fwd", 256'(unit_flush), 256'(1));
    step();
    flush = 1'b0;
    check("flush_busy", 256'(busy), 256'(0));
    unit_out_valid = 1'b1; resp_ready = '1;
    #1 check("flush_late_resp", 256'(resp_valid), 256'(0));
    step();
    unit_out_valid = 1'b0; resp_ready = '0;

    // Reset in the middle of an op owned by requester 2.
    req_valid = 4'b0100; unit_ready = 1'b1;
    step();
    req_valid = '0; unit_ready = 1'b0;
    repeat (3) step();
    unit_out_valid = 1'b1;
    #1 check("pre_rst_resp", 256'(resp_valid), 256'(4'b0100));
    rst_ni = 1'b0;
    #1;
    check("midrst_resp", 256'(resp_valid), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    unit_out_valid = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    req_valid = 4'b1000; unit_ready = 1'b1;
    #1 check("post_rst_ready", 256'(req_ready), 256'(4'b1000));
    step();
    req_valid = '0; unit_ready = 1'b0;
    check("post_rst_owner", 256'(owner), 256'(3));
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
